// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw pins and pulse enable in, conditioned levels and
// one-cycle press/release pulses out.
//   btn_raw     : raw button pins, active-high, asynchronous to clk
//   en          : pulse enable (levels keep tracking when low)
//   btn_level   : debounced level per channel
//   btn_press   : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0
//   any_press   : OR of btn_press, same cycle
// master = the side that owns the pins, slave = the conditioner.
interface btn_conditioner_if #(
   parameter int N_BTN = 2
);
   logic [N_BTN-1:0] btn_raw;
   logic             en;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic             any_press;

   modport master (
      output btn_raw, en,
      input  btn_level, btn_press, btn_release, any_press
   );

   modport slave (
      input  btn_raw, en,
      output btn_level, btn_press, btn_release, any_press
   );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces N_BTN raw push-buttons and
// emits single-cycle press/release pulses for the downstream reaction FSM.
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : btn_conditioner_if.slave (btn_raw, en in; btn_level, btn_press,
//           btn_release, any_press out, all registered)

// One channel: synchronizer chain -> debounce counter -> level + pulses.
module btn_channel #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic en,
   output logic level,
   output logic press,
   output logic rel,
   output logic press_nxt   // combinational press, feeds the registered any_press
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [CNT_W-1:0]       cnt;
   logic                   flip;

   assign sync_out  = sync_q[SYNC_STAGES-1];
   // Level flips on the edge where the disagreement has lasted DEBOUNCE_CYCLES samples.
   assign flip      = (sync_out != level) && (cnt == CNT_LAST);
   assign press_nxt = flip & sync_out & en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt    <= '0;
         level  <= 1'b0;
         press  <= 1'b0;
         rel    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         // Any agreement with the stored level restarts the count; no wrap.
         if (sync_out == level) begin
            cnt <= '0;
         end else if (flip) begin
            level <= sync_out;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         press <= press_nxt;
         rel   <= flip & ~sync_out & en;
      end
   end
endmodule

module btn_conditioner #(
   parameter int N_BTN           = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic               clk,
   input  logic               reset,
   btn_conditioner_if.slave   bus
);
   logic [N_BTN-1:0] level_v;
   logic [N_BTN-1:0] press_v;
   logic [N_BTN-1:0] rel_v;
   logic [N_BTN-1:0] press_nxt;
   logic             any_q;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .raw       (bus.btn_raw[gi]),
         .en        (bus.en),
         .level     (level_v[gi]),
         .press     (press_v[gi]),
         .rel       (rel_v[gi]),
         .press_nxt (press_nxt[gi])
      );
   end

   // Registered from the same next-state terms so it lines up with btn_press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) any_q <= 1'b0;
      else       any_q <= |press_nxt;
   end

   assign bus.btn_level   = level_v;
   assign bus.btn_press   = press_v;
   assign bus.btn_release = rel_v;
   assign bus.any_press   = any_q;
endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
   localparam int N  = 2;
   localparam int SS = 2;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_tot = 0;
   int   n_bad = 0;

   btn_conditioner_if #(.N_BTN(N)) bif ();

   btn_conditioner #(
      .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   // Reference: raw delayed by SS edges, then a level that only moves once the
   // delayed input has disagreed with it for DC consecutive edges.
   bit         hist [N][$];
   int         run_m [N];
   bit [N-1:0] lvl_m, exp_p, exp_r;
   bit         exp_any;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tot++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         hist[i].delete();
         repeat (SS) hist[i].push_back(1'b0);
         run_m[i] = 0;
      end
      lvl_m = '0; exp_p = '0; exp_r = '0; exp_any = 1'b0;
   endtask

   task automatic model_edge();
      bit s, prev;
      for (int i = 0; i < N; i++) begin
         s = hist[i].pop_front();
         hist[i].push_back(bif.btn_raw[i]);
         prev = lvl_m[i];
         if (s == lvl_m[i]) run_m[i] = 0;
         else if (run_m[i] + 1 >= DC) begin
            lvl_m[i] = s;
            run_m[i] = 0;
         end else run_m[i] = run_m[i] + 1;
         exp_p[i] = bif.en && !prev && lvl_m[i];
         exp_r[i] = bif.en && prev && !lvl_m[i];
      end
      exp_any = |exp_p;
   endtask

   // One clock edge: advance model, compare all outputs #1 after the edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("level",   32'(bif.btn_level),   32'(lvl_m));
      chk("press",   32'(bif.btn_press),   32'(exp_p));
      chk("release", 32'(bif.btn_release), 32'(exp_r));
      chk("any",     32'(bif.any_press),   32'(exp_any));
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Async reset asserted between edges, held across one edge, released mid-cycle.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk({tag, "_lvl"}, 32'(bif.btn_level),   32'd0);
      chk({tag, "_prs"}, 32'(bif.btn_press),   32'd0);
      chk({tag, "_rel"}, 32'(bif.btn_release), 32'd0);
      chk({tag, "_any"}, 32'(bif.any_press),   32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bif.btn_raw = '0;
      bif.en = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lvl", 32'(bif.btn_level), 32'd0);
      chk("rst_any", 32'(bif.any_press), 32'd0);
      #1;
      reset = 1'b0;

      // 1: clean press on btn0
      bif.btn_raw = 2'b01;
      ticks(5);
      chk("t1_lvl_e5", 32'(bif.btn_level), 32'd0);
      tick();
      chk("t1_lvl_e6", 32'(bif.btn_level), 32'h1);
      chk("t1_prs_e6", 32'(bif.btn_press), 32'h1);
      tick();
      chk("t1_prs_e7", 32'(bif.btn_press), 32'h0);
      ticks(3);
      chk("t1_hold",   32'(bif.btn_level), 32'h1);

      // 2: bounce on btn1, then steady
      bif.btn_raw = 2'b11; tick();
      bif.btn_raw = 2'b01; tick();
      bif.btn_raw = 2'b11; tick();
      bif.btn_raw = 2'b01; tick();
      bif.btn_raw = 2'b11;
      ticks(5);
      chk("t2_prs_e5", 32'(bif.btn_press), 32'h0);
      tick();
      chk("t2_prs_e6", 32'(bif.btn_press), 32'h2);
      ticks(2);

      // 3: release btn0
      bif.btn_raw = 2'b10;
      ticks(5);
      tick();
      chk("t3_rel", 32'(bif.btn_release), 32'h1);
      chk("t3_prs", 32'(bif.btn_press),   32'h0);
      chk("t3_lvl", 32'(bif.btn_level),   32'h2);
      ticks(2);

      // 4: enable gating
      bif.en = 1'b0;
      bif.btn_raw = 2'b11;
      ticks(6);
      chk("t4_lvl", 32'(bif.btn_level), 32'h3);
      chk("t4_prs", 32'(bif.btn_press), 32'h0);
      bif.en = 1'b1;
      ticks(3);
      chk("t4_noretro", 32'(bif.btn_press), 32'h0);
      bif.btn_raw = 2'b10;
      ticks(6);
      chk("t4_rel", 32'(bif.btn_release), 32'h1);

      // 5: simultaneous press
      bif.btn_raw = 2'b00;
      ticks(8);
      bif.btn_raw = 2'b11;
      ticks(5);
      tick();
      chk("t5_prs", 32'(bif.btn_press), 32'h3);
      chk("t5_any", 32'(bif.any_press), 32'h1);
      tick();
      chk("t5_prs_off", 32'(bif.btn_press), 32'h0);
      chk("t5_any_off", 32'(bif.any_press), 32'h0);

      // 6: reset mid-count with buttons held through reset
      bif.btn_raw = 2'b10;
      ticks(8);
      bif.btn_raw = 2'b11;
      ticks(4);
      do_reset("t6");
      ticks(5);
      chk("t6_prs_e5", 32'(bif.btn_press), 32'h0);
      tick();
      chk("t6_prs_e6", 32'(bif.btn_press), 32'h3);
      chk("t6_any_e6", 32'(bif.any_press), 32'h1);

      // Random chatter, enable toggling and occasional resets
      for (int it = 0; it < 1500; it++) begin
         bif.btn_raw = N'($urandom_range(0, (1 << N) - 1));
         bif.en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
         ticks($urandom_range(1, 8));
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
